ripple_count_monitor: RTL and testbench
=======================================

Name: ripple_count_monitor

Overview:
Downstream consumer of the 4-bit ripple-carry counter output.
- Brings the asynchronously rippling q bus into the clk domain through a two-flop synchronizer.
- Filters ripple glitches by accepting a value only once it has been stable.
- Checks that accepted values follow a legal +1 sequence.
- Counts wrap-arounds and reports step, wrap and error events to downstream logic.

Parameters:
WIDTH, 4, width of monitored counter bus
WRAP_W, 8, width of wrap-around event counter
STABLE_CYCLES, 2, consecutive identical synchronized samples required to accept a value (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
q_in  input  WIDTH  raw ripple-counter outputs (asynchronous to clk)
clr  input  1  synchronous clear of monitor state
count_out  output  WIDTH  last accepted (settled) counter value
valid  output  1  high once a first value has been accepted
step  output  1  one-cycle pulse on each legal +1 increment
wrap  output  1  one-cycle pulse on legal max→0 transition (step also high)
wrap_count  output  WRAP_W  number of wraps since reset/clr, saturating
err  output  1  sticky sequence-error flag
state  output  2  FSM state: 0 IDLE, 1 TRACK, 2 ERROR

Behaviour:
- Reset values (asynchronous, immediate on rst high):
  - count_out=0, valid=0, step=0, wrap=0, wrap_count=0, err=0, state=IDLE.
  - Synchronizer flops and stability counter are also cleared.
- Synchronizer: sync1<=q_in, sync2<=sync1 every clk edge.
- Stability filter:
  - When sync2 equals the previous sync2 sample, stab_cnt increments, saturating at STABLE_CYCLES.
  - When it differs, stab_cnt resets to 1.
  - A candidate is accepted on the edge where stab_cnt reaches STABLE_CYCLES and candidate != count_out (or state==IDLE).
- Latency: with the default parameters, q_in stable before edge E0 makes count_out update at edge E0+3.
- step/wrap: registered outputs, high for exactly the cycle after acceptance.
- FSM, and actions on each accepted value (new = accepted value, old = count_out):
  - IDLE: first accepted value loads count_out, sets valid=1 and goes to TRACK. No step.
  - TRACK, new==old+1 (mod 2^WIDTH): step=1. If old==all-ones and new==0, wrap=1 as well, and wrap_count increments, saturating at all-ones.
  - TRACK, new==0 and old!=all-ones: treated as upstream counter reset (resync). count_out=0, no step, no error, wrap_count unchanged.
  - TRACK, any other value: count_out=new, err=1, state goes to ERROR, no step.
  - ERROR: count_out keeps tracking accepted values. step and wrap pulses and wrap_count continue as in TRACK. err stays 1 and state stays ERROR until clr or rst.
- clr, synchronous:
  - Next edge: count_out=0, valid=0, err=0, wrap_count=0, step=wrap=0, state=IDLE.
  - Synchronizer contents kept; stab_cnt cleared.
  - clr wins over a simultaneous acceptance.
- A value equal to count_out never generates an event, however long it persists.
- Glitch rejection: a sync2 value shorter than STABLE_CYCLES samples is never accepted.
- rst asserted mid-operation clears everything immediately. After release, behaviour is identical to power-up.

Test Plan:
- Reset, then q_in=0 held 5 cycles -> valid=1 and count_out=0 at edge 3, state=TRACK, step never high.
- Sweep q_in 0..15 then 0, each value held 4 cycles -> 15 step pulses and exactly 1 wrap pulse coincident with the 15→0 step, wrap_count=1, err=0.
- From count_out=6, drive q_in 6→7 with a 1-cycle glitch value 4 in between (ripple) -> 4 not accepted, single step to 7, err=0.
- From count_out=3, drive q_in=9 stable -> count_out=9, err=1, state=ERROR, no step. Then assert clr 1 cycle -> err=0, valid=0, wrap_count=0, state=IDLE.
- From count_out=5, drive q_in=0 -> resync: count_out=0, err=0, no step, wrap_count unchanged. Then run 256+ wraps with WRAP_W=8 -> wrap_count saturates at 255.
- Assert rst mid-sweep at count_out=10 -> all outputs 0 and state=IDLE in the same cycle. After release, the first accepted value loads with no step.

Source files
------------

// File: rtl/ripple_count_monitor_if.sv
// Bundle between the ripple-counter monitor and its consumer: raw counter bus
// and clear in, settled value and event flags out.
interface ripple_count_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  q_in;
  logic              clr;
  logic [WIDTH-1:0]  count_out;
  logic              valid;
  logic              step;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_count;
  logic              err;
  logic [1:0]        state;

  modport master (output q_in, clr,
                  input  count_out, valid, step, wrap, wrap_count, err, state);
  modport slave  (input  q_in, clr,
                  output count_out, valid, step, wrap, wrap_count, err, state);
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronizes a rippling counter bus, filters glitches by stability, and
// checks that settled values advance by +1, counting wraps and flagging errors.
module ripple_count_monitor #(
  parameter int WIDTH         = 4,
  parameter int WRAP_W        = 8,
  parameter int STABLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  ripple_count_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ERROR = 2'd2} st_t;

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  st_t               st_q, st_d;
  logic [WIDTH-1:0]  sync1, sync2, prev_q, prev_d;
  logic [3:0]        stab_q, stab_d;
  logic              primed;
  logic [WIDTH-1:0]  cnt_q, cnt_d, inc;
  logic              valid_q, valid_d, step_q, step_d, wrap_q, wrap_d;
  logic              err_q, err_d, accept;
  logic [WRAP_W-1:0] wc_q, wc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  assign inc = cnt_q + 1'b1;

  always_comb begin
    st_d    = st_q;
    prev_d  = prev_q;
    stab_d  = stab_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    wc_d    = wc_q;
    err_d   = err_q;
    accept  = 1'b0;
    // sync2 still holds its reset value on the first edge, so it is skipped
    if (primed) begin
      prev_d = sync2;
      if (stab_q == 4'd0 || sync2 != prev_q) stab_d = 4'd1;
      else if (stab_q < STAB_MAX)            stab_d = stab_q + 4'd1;
      accept = (stab_d == STAB_MAX) && (sync2 != cnt_q || st_q == IDLE);
    end
    if (accept) begin
      cnt_d = sync2;
      if (st_q == IDLE) begin
        valid_d = 1'b1;
        st_d    = TRACK;
      end else if (sync2 == inc) begin
        step_d = 1'b1;
        if (cnt_q == '1) begin
          wrap_d = 1'b1;
          if (wc_q != '1) wc_d = wc_q + 1'b1;
        end
      end else if (sync2 != '0) begin
        // a jump to zero is an upstream reset and is silently resynced
        err_d = 1'b1;
        st_d  = ERROR;
      end
    end
    if (bus.clr) begin
      st_d    = IDLE;
      stab_d  = 4'd0;
      cnt_d   = '0;
      valid_d = 1'b0;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      wc_d    = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      primed  <= 1'b0;
      prev_q  <= '0;
      stab_q  <= 4'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      wc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1   <= bus.q_in;
      sync2   <= sync1;
      primed  <= 1'b1;
      prev_q  <= prev_d;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
    end
  end

  assign bus.count_out  = cnt_q;
  assign bus.valid      = valid_q;
  assign bus.step       = step_q;
  assign bus.wrap       = wrap_q;
  assign bus.wrap_count = wc_q;
  assign bus.err        = err_q;
  assign bus.state      = st_q;
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with hand-computed expectations.
module tb_ripple_count_monitor;
  logic clk, rst;
  int n_chk = 0, n_fail = 0;
  int steps, wraps, wrap_nostep, seen4;

  ripple_count_monitor_if #(.WIDTH(4), .WRAP_W(8)) bus ();
  ripple_count_monitor #(.WIDTH(4), .WRAP_W(8), .STABLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_acc();
    steps = 0; wraps = 0; wrap_nostep = 0; seen4 = 0;
  endtask

  // drive v for n edges, tallying event pulses as they appear
  task automatic hold(input logic [3:0] v, input int n);
    bus.q_in = v;
    repeat (n) begin
      tick();
      if (bus.step && !bus.wrap) steps++;
      if (bus.wrap) wraps++;
      if (bus.wrap && !bus.step) wrap_nostep++;
      if (bus.count_out == 4'd4) seen4++;
    end
  endtask

  task automatic sweep_to(input int first, input int last);
    for (int v = first; v <= last; v++) hold(4'(v), 4);
  endtask

  initial begin
    rst = 1'b1; bus.q_in = 4'd0; bus.clr = 1'b0;
    clr_acc();
    repeat (2) tick();
    chk("rst_count", bus.count_out, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_wc", bus.wrap_count, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_state", bus.state, 0);

    // first acceptance after reset lands on edge 3
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (bus.step) steps++;
      if (e == 2) chk("valid_e2", bus.valid, 0);
      if (e == 3) begin
        chk("valid_e3", bus.valid, 1);
        chk("count_e3", bus.count_out, 0);
        chk("state_e3", bus.state, 1);
      end
    end
    chk("first_no_step", steps, 0);

    // full sweep 0..15 then 0
    clr_acc();
    sweep_to(0, 15);
    hold(4'd0, 4);
    chk("sweep_plain_steps", steps, 15);
    chk("sweep_wraps", wraps, 1);
    chk("sweep_wrap_nostep", wrap_nostep, 0);
    chk("sweep_wc", bus.wrap_count, 1);
    chk("sweep_err", bus.err, 0);
    chk("sweep_count", bus.count_out, 0);

    // one-cycle ripple glitch between 6 and 7
    sweep_to(1, 6);
    clr_acc();
    hold(4'd4, 1);
    hold(4'd7, 5);
    chk("glitch_seen4", seen4, 0);
    chk("glitch_steps", steps, 1);
    chk("glitch_count", bus.count_out, 7);
    chk("glitch_err", bus.err, 0);

    // illegal jump 3 -> 9
    hold(4'd0, 4);
    sweep_to(1, 3);
    clr_acc();
    hold(4'd9, 5);
    chk("jump_count", bus.count_out, 9);
    chk("jump_err", bus.err, 1);
    chk("jump_state", bus.state, 2);
    chk("jump_steps", steps, 0);
    hold(4'd10, 5);
    chk("errst_steps", steps, 1);
    chk("errst_err", bus.err, 1);
    chk("errst_state", bus.state, 2);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_err", bus.err, 0);
    chk("clr_valid", bus.valid, 0);
    chk("clr_wc", bus.wrap_count, 0);
    chk("clr_state", bus.state, 0);
    chk("clr_count", bus.count_out, 0);
    clr_acc();
    hold(4'd10, 5);
    chk("reacq_count", bus.count_out, 10);
    chk("reacq_valid", bus.valid, 1);
    chk("reacq_steps", steps, 0);

    // resync 5 -> 0, then drive wrap_count into saturation
    sweep_to(11, 15);
    hold(4'd0, 4);
    sweep_to(1, 5);
    chk("pre_resync_wc", bus.wrap_count, 1);
    clr_acc();
    hold(4'd0, 5);
    chk("resync_count", bus.count_out, 0);
    chk("resync_err", bus.err, 0);
    chk("resync_steps", steps, 0);
    chk("resync_wc", bus.wrap_count, 1);
    clr_acc();
    for (int k = 1; k <= 260; k++) begin
      sweep_to(1, 15);
      hold(4'd0, 4);
      if (k == 253) chk("wc_254", bus.wrap_count, 254);
    end
    chk("wc_sat", bus.wrap_count, 255);
    chk("wc_wraps", wraps, 260);
    chk("wc_err", bus.err, 0);

    // asynchronous reset mid-sweep at 10
    sweep_to(1, 10);
    chk("pre_rst_count", bus.count_out, 10);
    bus.q_in = 4'd11;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_count", bus.count_out, 0);
    chk("arst_valid", bus.valid, 0);
    chk("arst_wc", bus.wrap_count, 0);
    chk("arst_state", bus.state, 0);
    tick();
    rst = 1'b0;
    clr_acc();
    hold(4'd11, 5);
    chk("post_rst_count", bus.count_out, 11);
    chk("post_rst_valid", bus.valid, 1);
    chk("post_rst_steps", steps, 0);
    chk("post_rst_state", bus.state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
